game_master_fsm_multi_shot: RTL and testbench

//  Round controller for the target/torpedo game, successor to the single-shot master FSM.

---
 rtl/game_master_fsm_multi_shot.sv | 120 ++++++++++++
 tb/tb_game_master_fsm_multi_shot.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_master_fsm_multi_shot.sv
// Round controller for the target/torpedo game: N_SHOTS launches per round and a saturating win score.
// Optional build macro GAME_KEY_EDGE_EN: fire on the rising edge of key instead of its level.
module game_master_fsm_multi_shot #(
  parameter int N_SHOTS = 3,
  parameter int SHOTS_W = 2,
  parameter int SCORE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               key,
  input  logic               sprite_target_within_screen,
  input  logic               sprite_torpedo_within_screen,
  input  logic               collision,
  input  logic               end_of_game_timer_running,
  output logic               sprite_target_write_xy,
  output logic               sprite_torpedo_write_xy,
  output logic               sprite_target_write_dxy,
  output logic               sprite_torpedo_write_dxy,
  output logic               sprite_target_enable_update,
  output logic               sprite_torpedo_enable_update,
  output logic               end_of_game_timer_start,
  output logic               game_won,
  output logic               game_lost,
  output logic [SHOTS_W-1:0] shots_left,
  output logic [SCORE_W-1:0] score
);

  typedef enum logic [7:0] {
    START_TARGET    = 8'b0000_0001,
    WAIT_KEY        = 8'b0000_0010,
    START_TORPEDO   = 8'b0000_0100,
    WAIT_COLLISION  = 8'b0000_1000,
    RELOAD          = 8'b0001_0000,
    START_END_TIMER = 8'b0010_0000,
    GAME_WON        = 8'b0100_0000,
    GAME_LOST       = 8'b1000_0000
  } state_t;

  state_t state;
  state_t state_nx;
  logic   collision_reg;
  logic   fire;
  logic   shots_avail;

`ifdef GAME_KEY_EDGE_EN
  logic key_d;
  assign fire = key & ~key_d;
`else
  assign fire = key;
`endif

  assign shots_avail = (shots_left != '0);

  always_comb begin
    state_nx = START_TARGET;
    case (state)
      START_TARGET:    state_nx = WAIT_KEY;
      WAIT_KEY: begin
        if (fire && shots_avail)               state_nx = START_TORPEDO;
        else if (!sprite_target_within_screen) state_nx = START_END_TIMER;
        else                                   state_nx = WAIT_KEY;
      end
      START_TORPEDO:   state_nx = WAIT_COLLISION;
      WAIT_COLLISION: begin
        if (collision || !sprite_target_within_screen) state_nx = START_END_TIMER;
        else if (!sprite_torpedo_within_screen)        state_nx = shots_avail ? RELOAD : START_END_TIMER;
        else                                           state_nx = WAIT_COLLISION;
      end
      RELOAD:          state_nx = WAIT_KEY;
      START_END_TIMER: state_nx = collision_reg ? GAME_WON : GAME_LOST;
      GAME_WON:        state_nx = end_of_game_timer_running ? GAME_WON : START_TARGET;
      GAME_LOST:       state_nx = end_of_game_timer_running ? GAME_LOST : START_TARGET;
      default:         state_nx = START_TARGET;
    endcase
  end

  // Outputs are registered from the next state so they always match the decode of the current state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                        <= START_TARGET;
      shots_left                   <= SHOTS_W'(N_SHOTS);
      score                        <= '0;
      collision_reg                <= 1'b0;
      sprite_target_write_xy       <= 1'b1;
      sprite_target_write_dxy      <= 1'b1;
      sprite_torpedo_write_xy      <= 1'b1;
      sprite_torpedo_write_dxy     <= 1'b0;
      sprite_target_enable_update  <= 1'b0;
      sprite_torpedo_enable_update <= 1'b0;
      end_of_game_timer_start      <= 1'b0;
      game_won                     <= 1'b0;
      game_lost                    <= 1'b0;
`ifdef GAME_KEY_EDGE_EN
      key_d                        <= 1'b0;
`endif
    end else begin
      state                        <= state_nx;
      collision_reg                <= collision;
      sprite_target_write_xy       <= (state_nx == START_TARGET);
      sprite_target_write_dxy      <= (state_nx == START_TARGET);
      sprite_torpedo_write_xy      <= (state_nx == START_TARGET) || (state_nx == RELOAD);
      sprite_torpedo_write_dxy     <= (state_nx == WAIT_KEY) || (state_nx == WAIT_COLLISION);
      sprite_target_enable_update  <= (state_nx == WAIT_KEY) || (state_nx == WAIT_COLLISION);
      sprite_torpedo_enable_update <= (state_nx == WAIT_COLLISION);
      end_of_game_timer_start      <= (state_nx == START_END_TIMER);
      game_won                     <= (state_nx == GAME_WON);
      game_lost                    <= (state_nx == GAME_LOST);
`ifdef GAME_KEY_EDGE_EN
      key_d                        <= key;
`endif
      case (state)
        START_TARGET:    shots_left <= SHOTS_W'(N_SHOTS);
        START_TORPEDO:   shots_left <= shots_left - SHOTS_W'(1);
        START_END_TIMER: if (collision_reg && (score != '1)) score <= score + SCORE_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_game_master_fsm_multi_shot.sv
// Randomized round-level bench for game_master_fsm_multi_shot; a monitor checks reload and round-end events against a queue.
module tb_game_master_fsm_multi_shot;

  localparam int N         = 3;
  localparam int SHOTS_W   = 2;
  localparam int SCORE_W   = 4;
  localparam int SCORE_MAX = (1 << SCORE_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key = 1'b0;
  logic target_within = 1'b1;
  logic torpedo_within = 1'b1;
  logic collision = 1'b0;
  logic timer_running = 1'b1;
  logic target_write_xy, torpedo_write_xy, target_write_dxy, torpedo_write_dxy;
  logic target_enable_update, torpedo_enable_update, timer_start, game_won, game_lost;
  logic [SHOTS_W-1:0] shots_left;
  logic [SCORE_W-1:0] score;

  game_master_fsm_multi_shot #(.N_SHOTS(N), .SHOTS_W(SHOTS_W), .SCORE_W(SCORE_W)) dut (
    .clk                          (clk),
    .reset                        (rst),
    .key                          (key),
    .sprite_target_within_screen  (target_within),
    .sprite_torpedo_within_screen (torpedo_within),
    .collision                    (collision),
    .end_of_game_timer_running    (timer_running),
    .sprite_target_write_xy       (target_write_xy),
    .sprite_torpedo_write_xy      (torpedo_write_xy),
    .sprite_target_write_dxy      (target_write_dxy),
    .sprite_torpedo_write_dxy     (torpedo_write_dxy),
    .sprite_target_enable_update  (target_enable_update),
    .sprite_torpedo_enable_update (torpedo_enable_update),
    .end_of_game_timer_start      (timer_start),
    .game_won                     (game_won),
    .game_lost                    (game_lost),
    .shots_left                   (shots_left),
    .score                        (score)
  );

  always #5 clk = ~clk;

  // kind 0: torpedo reload, kind 1: round end
  typedef struct {
    int   kind;
    logic won;
    int   score;
    int   shots;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  int   score_m  = 0;
  logic end_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic summary_and_finish();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  endtask

  // Observable phases: 0 waiting for key, 1 torpedo in flight, 2 round over, 3 round setup
  function automatic bit pred(input int w);
    case (w)
      0:       return torpedo_write_dxy && !torpedo_enable_update;
      1:       return torpedo_enable_update;
      2:       return game_won || game_lost;
      default: return target_write_xy;
    endcase
  endfunction

  task automatic wait_for(input int w);
    for (int i = 0; i < 300; i++) begin
      if (pred(w)) return;
      @(negedge clk);
    end
    n_checks++;
    n_errs++;
    $display("FAIL timeout_phase_%0d: got no event expected event within 300 cycles", w);
    summary_and_finish();
  endtask

  task automatic push(input int kind, input logic won, input int sc, input int sh);
    exp_t e;
    e.kind = kind; e.won = won; e.score = sc; e.shots = sh;
    q.push_back(e);
  endtask

  task automatic launch();
    wait_for(0);
    key = 1'b1;
    @(negedge clk);
    key = 1'b0;
    wait_for(1);
    repeat ($urandom_range(0, 6)) @(negedge clk);
  endtask

  task automatic miss(input int launch_no);
    if (launch_no < N) push(0, 1'b0, 0, N - launch_no);
    else               push(1, 1'b0, score_m, 0);
    torpedo_within = 1'b0;
    @(negedge clk);
    torpedo_within = 1'b1;
  endtask

  task automatic end_round();
    wait_for(2);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    check("outcome_held_while_timer", game_won || game_lost, 1);
    timer_running = 1'b0;
    @(negedge clk);
    wait_for(3);
    timer_running = 1'b1;
  endtask

  task automatic run_round(input int t);
    int i;
    wait_for(0);
    check("shots_at_round_start", shots_left, N);
    i = $urandom_range(0, N - 1);
    case (t)
      0, 1, 5: begin
        for (int j = 1; j <= i; j++) begin launch(); miss(j); end
        launch();
        score_m = (score_m < SCORE_MAX) ? score_m + 1 : SCORE_MAX;
        push(1, 1'b1, score_m, N - i - 1);
        collision = 1'b1;
        if (t == 5) target_within = 1'b0;
        @(negedge clk);
        collision = 1'b0;
        target_within = 1'b1;
      end
      2: for (int j = 1; j <= N; j++) begin launch(); miss(j); end
      3: begin
        for (int j = 1; j <= i; j++) begin launch(); miss(j); end
        wait_for(0);
        push(1, 1'b0, score_m, N - i);
        target_within = 1'b0;
        @(negedge clk);
        target_within = 1'b1;
      end
      default: begin
        for (int j = 1; j <= i; j++) begin launch(); miss(j); end
        launch();
        push(1, 1'b0, score_m, N - i - 1);
        target_within = 1'b0;
        @(negedge clk);
        target_within = 1'b1;
      end
    endcase
    end_round();
  endtask

  task automatic check_evt(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL unexpected_event: got kind %0d expected no event at %0t", kind, $time);
      return;
    end
    e = q.pop_front();
    check("event_kind", kind, e.kind);
    check("event_shots_left", shots_left, e.shots);
    if (kind == 1) begin
      check("end_game_won", game_won, e.won);
      check("end_game_lost", game_lost, !e.won);
      check("end_score", score, e.score);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      end_prev = 1'b0;
    end else begin
      if (torpedo_write_xy && !target_write_xy) check_evt(0);
      if ((game_won || game_lost) && !end_prev) check_evt(1);
      end_prev = game_won || game_lost;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_target_write_xy", target_write_xy, 1);
    check("rst_target_write_dxy", target_write_dxy, 1);
    check("rst_torpedo_write_xy", torpedo_write_xy, 1);
    check("rst_enables", {target_enable_update, torpedo_enable_update, torpedo_write_dxy}, 0);
    check("rst_end_outputs", {timer_start, game_won, game_lost}, 0);
    check("rst_shots_left", shots_left, N);
    check("rst_score", score, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_wait_key", pred(0), 1);

    for (int r = 0; r < 80; r++) run_round((r < 18) ? 0 : int'($urandom_range(0, 5)));

    // Reset asserted between edges while the torpedo is flying.
    wait_for(0);
    launch();
    #2 rst = 1'b1;
    #1;
    check("midrst_target_write_xy", target_write_xy, 1);
    check("midrst_torpedo_enable", torpedo_enable_update, 0);
    check("midrst_score", score, 0);
    check("midrst_shots_left", shots_left, N);
    score_m = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int r = 0; r < 6; r++) run_round(int'($urandom_range(0, 5)));

    wait_for(0);
    check("held_start_shots", shots_left, N);
    key = 1'b1;
`ifdef GAME_KEY_EDGE_EN
    wait_for(1);
    miss(1);
    repeat (200) @(negedge clk);
    check("held_key_in_wait_key", pred(0), 1);
    check("held_key_shots_left", shots_left, N - 1);
    key = 1'b0;
    push(1, 1'b0, score_m, N - 1);
    target_within = 1'b0;
    @(negedge clk);
    target_within = 1'b1;
`else
    for (int j = 1; j <= N; j++) begin
      wait_for(1);
      miss(j);
    end
    key = 1'b0;
`endif
    end_round();

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    summary_and_finish();
  end

endmodule
